// File: rtl/battle_referee_if.sv
// Signal bundle between the battle referee, the mode/keyboard front end,
// the turn timer and the score display.
interface battle_referee_if #(
    parameter int SCORE_W = 8
);
    logic               start;
    logic               abort;
    logic               note_strobe;
    logic               timer;
    logic               battle;
    logic               restart;
    logic               player;
    logic               busy;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [1:0]         winner;
    logic               done;

    modport master (
        output start, abort, note_strobe, timer,
        input  battle, restart, player, busy, score_p1, score_p2, winner, done
    );

    modport slave (
        input  start, abort, note_strobe, timer,
        output battle, restart, player, busy, score_p1, score_p2, winner, done
    );
endinterface

// File: rtl/battle_referee.sv
// Piano battle referee: alternates P1/P2 turns, drives the turn timer,
// counts notes per player and declares the winner.
//
// state  | meaning
// IDLE   | no battle running, waiting for start
// ARM    | one cycle between turns, timer cleared via restart
// PLAY   | active player's turn, timer counting, notes scored
// RESULT | battle over, winner valid, scores held
module battle_referee #(
    parameter int SCORE_W = 8,
    parameter int ROUNDS  = 1
) (
    input  logic             clk,
    input  logic             reset,
    battle_referee_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        PLAY   = 2'd2,
        RESULT = 2'd3
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS - 1);

    state_t             state_q, state_d;
    logic               player_q, player_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               battle_q, battle_d;
    logic               restart_q, restart_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         winner_q, winner_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            player_q   <= 1'b0;
            round_q    <= 4'd0;
            score_p1_q <= '0;
            score_p2_q <= '0;
            battle_q   <= 1'b0;
            restart_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            round_q    <= round_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            battle_q   <= battle_d;
            restart_q  <= restart_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        round_d    = round_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        restart_d  = 1'b0;

        case (state_q)
            IDLE, RESULT: begin
                if (bus.start) begin
                    state_d    = ARM;
                    player_d   = 1'b0;
                    round_d    = 4'd0;
                    score_p1_d = '0;
                    score_p2_d = '0;
                end
            end
            ARM: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    restart_d = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A note landing with abort or timer still belongs to the ending turn.
                if (bus.note_strobe) begin
                    if (!player_q && score_p1_q != SCORE_MAX)
                        score_p1_d = score_p1_q + SCORE_ONE;
                    if (player_q && score_p2_q != SCORE_MAX)
                        score_p2_d = score_p2_q + SCORE_ONE;
                end
                if (bus.abort) begin
                    state_d   = IDLE;
                    restart_d = 1'b1;
                end else if (bus.timer) begin
                    if (!player_q) begin
                        player_d = 1'b1;
                        state_d  = ARM;
                    end else if (round_q != LAST_ROUND) begin
                        round_d  = round_q + 4'd1;
                        player_d = 1'b0;
                        state_d  = ARM;
                    end else begin
                        state_d = RESULT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == ARM)
            restart_d = 1'b1;
        battle_d = (state_d == PLAY);
        busy_d   = (state_d == ARM) || (state_d == PLAY);
        done_d   = (state_d == RESULT) && (state_q != RESULT);

        winner_d = 2'b00;
        if (state_d == RESULT) begin
            if (score_p1_d > score_p2_d)
                winner_d = 2'b01;
            else if (score_p2_d > score_p1_d)
                winner_d = 2'b10;
            else
                winner_d = 2'b11;
        end
    end

    assign bus.battle   = battle_q;
    assign bus.restart  = restart_q;
    assign bus.player   = player_q;
    assign bus.busy     = busy_q;
    assign bus.score_p1 = score_p1_q;
    assign bus.score_p2 = score_p2_q;
    assign bus.winner   = winner_q;
    assign bus.done     = done_q;
endmodule
